// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that funnels NREQ write-back requesters onto one
// registered register-file write port, with a busy mask for hazard checks.
module regfile_wb_arbiter #(
    parameter int NREQ = 4,
    parameter int XLEN = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*5-1:0]         req_reg,
    input  logic [NREQ*XLEN-1:0]      req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      freeze,
    output logic                      rf_write,
    output logic [4:0]                rf_writeReg,
    output logic [XLEN-1:0]           rf_writeData,
    output logic [31:0]               busy_mask,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            rf_write_q, rf_write_d;
    logic [4:0]      rf_reg_q, rf_reg_d;
    logic [XLEN-1:0] rf_data_q, rf_data_d;
    logic [PW-1:0]   grant_q, grant_d;

    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   cand;
    logic            found;
    int              idx;
    logic [4:0]      sel_reg;
    logic [XLEN-1:0] sel_data;

    // Search ptr, ptr+1, ... modulo NREQ; the first valid requester wins.
    always_comb begin
        req_ready = '0;
        gnt_idx   = '0;
        cand      = '0;
        found     = 1'b0;
        idx       = 0;
        if (rst_n && !freeze) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                cand = PW'(idx);
                if (!found && req_valid[cand]) begin
                    found   = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        if (found) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        sel_reg  = req_reg[int'(gnt_idx)*5 +: 5];
        sel_data = req_data[int'(gnt_idx)*XLEN +: XLEN];

        ptr_d      = ptr_q;
        rf_write_d = 1'b0;
        rf_reg_d   = rf_reg_q;
        rf_data_d  = rf_data_q;
        grant_d    = grant_q;
        if (found) begin
            if (int'(gnt_idx) == NREQ - 1) ptr_d = '0;
            else                           ptr_d = gnt_idx + PW'(1);
            // Register 0 is accepted and consumed but never written.
            rf_write_d = (sel_reg != 5'd0);
            rf_reg_d   = sel_reg;
            rf_data_d  = sel_data;
            grant_d    = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            rf_write_q <= 1'b0;
            rf_reg_q   <= '0;
            rf_data_q  <= '0;
            grant_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rf_write_q <= rf_write_d;
            rf_reg_q   <= rf_reg_d;
            rf_data_q  <= rf_data_d;
            grant_q    <= grant_d;
        end
    end

    assign rf_write     = rf_write_q;
    assign rf_writeReg  = rf_reg_q;
    assign rf_writeData = rf_data_q;
    assign busy_mask    = rf_write_q ? (32'd1 << rf_reg_q) : 32'd0;
    // The held grant is only meaningful while a write is on the port.
    assign grant_id     = rf_write_q ? grant_q : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NREQ=4, XLEN=32): reset, round-robin
// order, reg-0 writes, same-register conflicts, freeze and mid-stream reset.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 4;
    localparam int XLEN = 32;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*5-1:0]    req_reg;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 freeze;
    logic                 rf_write;
    logic [4:0]           rf_writeReg;
    logic [XLEN-1:0]      rf_writeData;
    logic [31:0]          busy_mask;
    logic [1:0]           grant_id;

    int checks;
    int failures;

    regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_reg      (req_reg),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .freeze       (freeze),
        .rf_write     (rf_write),
        .rf_writeReg  (rf_writeReg),
        .rf_writeData (rf_writeData),
        .busy_mask    (busy_mask),
        .grant_id     (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] r, input logic [XLEN-1:0] d);
        req_reg[5*i +: 5]        = r;
        req_data[XLEN*i +: XLEN] = d;
    endtask

    task automatic chk_write(input string tag, input logic [4:0] r, input logic [31:0] d,
                             input logic [1:0] g);
        chk({tag, "_wr"},   {63'd0, rf_write}, 64'd1);
        chk({tag, "_reg"},  {59'd0, rf_writeReg}, {59'd0, r});
        chk({tag, "_data"}, {32'd0, rf_writeData}, {32'd0, d});
        chk({tag, "_gid"},  {62'd0, grant_id}, {62'd0, g});
        chk({tag, "_busy"}, {32'd0, busy_mask}, {32'd0, 32'd1 << r});
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        freeze    = 1'b0;
        req_valid = 4'b1111;
        req_reg   = '0;
        req_data  = '0;

        // Reset: ready gated off even with every requester valid.
        #1;
        chk("rst_ready", {60'd0, req_ready}, 64'd0);
        cycle();
        cycle();
        chk("rst_ready2", {60'd0, req_ready}, 64'd0);
        chk("rst_wr",    {63'd0, rf_write}, 64'd0);
        chk("rst_reg",   {59'd0, rf_writeReg}, 64'd0);
        chk("rst_data",  {32'd0, rf_writeData}, 64'd0);
        chk("rst_gid",   {62'd0, grant_id}, 64'd0);
        chk("rst_busy",  {32'd0, busy_mask}, 64'd0);

        // All four valid with regs 1..4 -> grants 0,1,2,3,0.
        set_req(0, 5'd1, 32'hA0);
        set_req(1, 5'd2, 32'hA1);
        set_req(2, 5'd3, 32'hA2);
        set_req(3, 5'd4, 32'hA3);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("rr_ready", {60'd0, req_ready}, {60'd0, 4'b0001 << (c % 4)});
            cycle();
            chk_write("rr", 5'((c % 4) + 1), 32'hA0 + 32'(c % 4), 2'(c % 4));
        end

        // Idle: rf_write drops, index and data hold; ptr now 1.
        req_valid = 4'b0000;
        #1;
        chk("idle_ready", {60'd0, req_ready}, 64'd0);
        cycle();
        chk("idle_wr",   {63'd0, rf_write}, 64'd0);
        chk("idle_reg",  {59'd0, rf_writeReg}, 64'd1);
        chk("idle_data", {32'd0, rf_writeData}, 64'hA0);
        chk("idle_busy", {32'd0, busy_mask}, 64'd0);
        chk("idle_gid",  {62'd0, grant_id}, 64'd0);

        // Lone requester 2 granted on every one of three cycles.
        set_req(2, 5'd7, 32'hDEADBEEF);
        req_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("solo_ready", {60'd0, req_ready}, 64'b0100);
            cycle();
            chk_write("solo", 5'd7, 32'hDEADBEEF, 2'd2);
        end

        // Requester 1 writes reg 0 (ptr=3 -> search 3,0,1): accepted, no write.
        set_req(1, 5'd0, 32'h1234);
        req_valid = 4'b0010;
        #1;
        chk("r0_ready", {60'd0, req_ready}, 64'b0010);
        cycle();
        chk("r0_wr",   {63'd0, rf_write}, 64'd0);
        chk("r0_busy", {32'd0, busy_mask}, 64'd0);
        chk("r0_data", {32'd0, rf_writeData}, 64'h1234);
        chk("r0_gid",  {62'd0, grant_id}, 64'd0);

        // ptr should now be 2: with all valid requester 2 wins.
        set_req(2, 5'd3, 32'hA2);
        req_valid = 4'b1111;
        #1;
        chk("ptr2_ready", {60'd0, req_ready}, 64'b0100);
        cycle();
        chk_write("ptr2", 5'd3, 32'hA2, 2'd2);

        // ptr=3, requesters 0 and 3 both target reg 5: 3 first, then 0.
        set_req(0, 5'd5, 32'h11);
        set_req(3, 5'd5, 32'h33);
        req_valid = 4'b1001;
        #1;
        chk("same_ready1", {60'd0, req_ready}, 64'b1000);
        cycle();
        chk_write("same1", 5'd5, 32'h33, 2'd3);
        req_valid = 4'b0001;
        #1;
        chk("same_ready2", {60'd0, req_ready}, 64'b0001);
        cycle();
        chk_write("same2", 5'd5, 32'h11, 2'd0);

        // Freeze two cycles with 0 and 1 valid (ptr=1); registered write survives.
        set_req(0, 5'd10, 32'h100);
        set_req(1, 5'd11, 32'h101);
        req_valid = 4'b0011;
        freeze    = 1'b1;
        #1;
        chk("frz_ready1", {60'd0, req_ready}, 64'd0);
        chk("frz_keep_wr",  {63'd0, rf_write}, 64'd1);
        chk("frz_keep_reg", {59'd0, rf_writeReg}, 64'd5);
        cycle();
        chk("frz_wr1", {63'd0, rf_write}, 64'd0);
        chk("frz_ready2", {60'd0, req_ready}, 64'd0);
        cycle();
        chk("frz_wr2", {63'd0, rf_write}, 64'd0);
        freeze = 1'b0;
        #1;
        chk("unfrz_ready1", {60'd0, req_ready}, 64'b0010);
        cycle();
        chk_write("unfrz1", 5'd11, 32'h101, 2'd1);
        req_valid = 4'b0001;
        #1;
        chk("unfrz_ready2", {60'd0, req_ready}, 64'b0001);
        cycle();
        chk_write("unfrz2", 5'd10, 32'h100, 2'd0);

        // Mid-stream reset discards the reg-9 write; requester 0 wins after.
        set_req(2, 5'd9, 32'h99);
        req_valid = 4'b0100;
        #1;
        chk("mrst_ready", {60'd0, req_ready}, 64'b0100);
        cycle();
        chk_write("mrst_pre", 5'd9, 32'h99, 2'd2);
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("mrst_ready_rst", {60'd0, req_ready}, 64'd0);
        cycle();
        chk("mrst_wr",   {63'd0, rf_write}, 64'd0);
        chk("mrst_reg",  {59'd0, rf_writeReg}, 64'd0);
        chk("mrst_busy", {32'd0, busy_mask}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("mrst_ready_post", {60'd0, req_ready}, 64'b0001);
        cycle();
        chk_write("mrst_post", 5'd10, 32'h100, 2'd0);

        req_valid = 4'b0000;
        cycle();
        chk("end_wr", {63'd0, rf_write}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
